// File: rtl/bias_stream_if.sv
// ROM read port and ap_fifo output stream of the bias streamer, bundled as one interface.
// master = sequencer side, slave = ROM + downstream FIFO side.
interface bias_stream_if #(
    parameter int ADDR_W     = 4,
    parameter int DATA_WIDTH = 16
);
    logic [ADDR_W-1:0]     rom_address;
    logic                  rom_ce;
    logic [DATA_WIDTH-1:0] rom_q;
    logic [DATA_WIDTH-1:0] output_V_din;
    logic                  output_V_full_n;
    logic                  output_V_write;

    modport master (
        output rom_address, rom_ce, output_V_din, output_V_write,
        input  rom_q, output_V_full_n
    );
    modport slave (
        input  rom_address, rom_ce, output_V_din, output_V_write,
        output rom_q, output_V_full_n
    );
endinterface

// File: rtl/bias_stream_ctrl.sv
// Bias ROM sequencer: streams BIAS_N words NUM_PIX times per ap_start through a
// 2-entry skid buffer that absorbs the 1-cycle ROM latency and downstream backpressure.
module bias_stream_ctrl #(
    parameter  int BIAS_N     = 16,
    parameter  int NUM_PIX    = 4,
    parameter  int DATA_WIDTH = 16,
    localparam int ADDR_W     = (BIAS_N > 1) ? $clog2(BIAS_N) : 1,
    localparam int PASS_W     = (NUM_PIX > 1) ? $clog2(NUM_PIX + 1) : 1
) (
    input  logic ap_clk,
    input  logic ap_rst_n,
    input  logic ap_start,
    output logic ap_idle,
    output logic ap_done,
    output logic ap_ready,
    bias_stream_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                          state_q, state_d;
    logic [ADDR_W-1:0]               addr_q, addr_d;
    logic [PASS_W-1:0]               pass_q, pass_d;
    logic [1:0]                      occ_q, occ_d;
    logic                            inflight_q;
    logic [1:0][DATA_WIDTH-1:0]      buf_q, buf_d;
    logic                            pop, issue, last_rd, addr_wrap;

    assign pop       = (occ_q != 2'd0) && bus.output_V_full_n;
    assign addr_wrap = (addr_q == ADDR_W'(BIAS_N - 1));
    assign last_rd   = addr_wrap && (pass_q == PASS_W'(NUM_PIX - 1));
    // Never own more than two words: buffered + in flight, net of this cycle's pop.
    assign issue     = (state_q == S_RUN) &&
                       (({1'b0, occ_q} + {2'b0, inflight_q} - {2'b0, pop}) < 3'd2);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        pass_d  = pass_q;
        occ_d   = occ_q;
        buf_d   = buf_q;

        case ({inflight_q, pop})
            2'b01: begin
                buf_d[0] = buf_q[1];
                occ_d    = occ_q - 2'd1;
            end
            2'b10: begin
                if (occ_q == 2'd0) buf_d[0] = bus.rom_q;
                else               buf_d[1] = bus.rom_q;
                occ_d = occ_q + 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    buf_d[0] = bus.rom_q;
                end else begin
                    buf_d[0] = buf_q[1];
                    buf_d[1] = bus.rom_q;
                end
            end
            default: ;
        endcase

        case (state_q)
            S_IDLE: if (ap_start) begin
                state_d = S_RUN;
                addr_d  = '0;
                pass_d  = '0;
            end
            S_RUN: if (issue) begin
                if (addr_wrap) begin
                    addr_d = '0;
                    pass_d = pass_q + PASS_W'(1);
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
                if (last_rd) state_d = S_DRAIN;
            end
            // Leave as the final buffered word is popped so ap_done lands right after it.
            S_DRAIN: if (!inflight_q && occ_d == 2'd0) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            pass_q     <= '0;
            occ_q      <= '0;
            inflight_q <= 1'b0;
            buf_q      <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            pass_q     <= pass_d;
            occ_q      <= occ_d;
            inflight_q <= issue;
            buf_q      <= buf_d;
        end
    end

    assign ap_idle            = (state_q == S_IDLE);
    assign ap_done            = (state_q == S_DONE);
    assign ap_ready           = ap_done;
    assign bus.rom_ce         = issue;
    assign bus.rom_address    = addr_q;
    assign bus.output_V_din   = buf_q[0];
    assign bus.output_V_write = pop;
endmodule

// File: tb/tb_bias_stream_ctrl.sv
// Three streamer configurations (4x2, 16x4, 1x1) checked every cycle against a word-queue model.
module tb_bias_stream_ctrl;
    logic       ap_clk = 1'b0;
    logic [2:0] rst_n, start, idle, done, ready;
    int         gc = 0;
    int         vectors = 0, miscompares = 0;
    logic       rnd = 1'b0;

    logic [15:0] rom0 [4];
    logic [15:0] rom1 [16];
    logic [15:0] rom2 [1];
    int bn [3] = '{4, 16, 1};
    int np [3] = '{2, 4, 1};

    int   q [3][$];
    int   got [3][$];
    int   ce_tot [3], wr_tot [3], done_cnt [3], st_gc [3], first_wr [3], last_wr [3], done_cyc [3];
    logic wr_at [3][256];

    bias_stream_if #(.ADDR_W(2), .DATA_WIDTH(16)) ifa ();
    bias_stream_if #(.ADDR_W(4), .DATA_WIDTH(16)) ifb ();
    bias_stream_if #(.ADDR_W(1), .DATA_WIDTH(16)) ifc ();

    bias_stream_ctrl #(.BIAS_N(4), .NUM_PIX(2), .DATA_WIDTH(16)) u0 (
        .ap_clk(ap_clk), .ap_rst_n(rst_n[0]), .ap_start(start[0]), .ap_idle(idle[0]),
        .ap_done(done[0]), .ap_ready(ready[0]), .bus(ifa));
    bias_stream_ctrl #(.BIAS_N(16), .NUM_PIX(4), .DATA_WIDTH(16)) u1 (
        .ap_clk(ap_clk), .ap_rst_n(rst_n[1]), .ap_start(start[1]), .ap_idle(idle[1]),
        .ap_done(done[1]), .ap_ready(ready[1]), .bus(ifb));
    bias_stream_ctrl #(.BIAS_N(1), .NUM_PIX(1), .DATA_WIDTH(16)) u2 (
        .ap_clk(ap_clk), .ap_rst_n(rst_n[2]), .ap_start(start[2]), .ap_idle(idle[2]),
        .ap_done(done[2]), .ap_ready(ready[2]), .bus(ifc));

    always #5 ap_clk = ~ap_clk;
    always @(posedge ap_clk) gc <= gc + 1;

    // Synchronous ROMs with one cycle of read latency.
    always @(posedge ap_clk) begin
        if (ifa.rom_ce) ifa.rom_q <= rom0[ifa.rom_address];
        if (ifb.rom_ce) ifb.rom_q <= rom1[ifb.rom_address];
        if (ifc.rom_ce) ifc.rom_q <= rom2[ifc.rom_address];
    end

    function automatic int rom_word(int k, int i);
        case (k)
            0:       return int'(rom0[i]);
            1:       return int'(rom1[i]);
            default: return int'(rom2[i]);
        endcase
    endfunction

    task automatic cmp(string nm, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic mon(int k, logic rn, logic idl, logic dn, logic rdy, logic ce, logic wr,
                       logic [15:0] din, logic fn);
        int c;
        c = gc - st_gc[k];
        if (!rn) begin
            cmp("reset_outputs", int'({idl, dn, rdy, ce, wr}), 5'b10000);
            cmp("reset_din", int'(din), 0);
            q[k].delete();
            ce_tot[k] = 0;
            wr_tot[k] = 0;
            return;
        end
        cmp("ready_eq_done", int'(rdy), int'(dn));
        if (wr) begin
            cmp("write_while_full", int'(fn), 1);
            if (q[k].size() == 0) cmp("extra_word", 0, 1);
            else                  cmp("din", int'(din), q[k].pop_front());
            got[k].push_back(int'(din));
            wr_tot[k]++;
            if (first_wr[k] < 0) first_wr[k] = c;
            last_wr[k] = c;
            if (c >= 0 && c < 256) wr_at[k][c] = 1'b1;
        end
        if (ce) ce_tot[k]++;
        cmp("owned_le_2", int'((ce_tot[k] - wr_tot[k]) <= 2), 1);
        if (dn) begin
            done_cnt[k]++;
            done_cyc[k] = c;
            cmp("done_queue_empty", q[k].size(), 0);
            cmp("done_after_last_write", c, last_wr[k] + 1);
            cmp("reads_issued", ce_tot[k], bn[k] * np[k]);
        end
    endtask

    always @(negedge ap_clk) begin
        mon(0, rst_n[0], idle[0], done[0], ready[0], ifa.rom_ce, ifa.output_V_write,
            ifa.output_V_din, ifa.output_V_full_n);
        mon(1, rst_n[1], idle[1], done[1], ready[1], ifb.rom_ce, ifb.output_V_write,
            ifb.output_V_din, ifb.output_V_full_n);
        mon(2, rst_n[2], idle[2], done[2], ready[2], ifc.rom_ce, ifc.output_V_write,
            ifc.output_V_din, ifc.output_V_full_n);
    end

    task automatic step(int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge ap_clk);
            #1;
            if (rnd) ifb.output_V_full_n = 1'($urandom_range(0, 1));
        end
    endtask

    // Called only while the instance is known idle; the ap_start cycle becomes cycle 0.
    task automatic do_start(int k);
        q[k].delete();
        got[k].delete();
        ce_tot[k]   = 0;
        wr_tot[k]   = 0;
        first_wr[k] = -1;
        last_wr[k]  = -100;
        for (int c = 0; c < 256; c++) wr_at[k][c] = 1'b0;
        for (int i = 0; i < bn[k] * np[k]; i++) q[k].push_back(rom_word(k, i % bn[k]));
        st_gc[k] = gc;
        start[k] = 1'b1;
        step();
        start[k] = 1'b0;
    endtask

    task automatic wait_done(int k, int budget);
        int d0, n;
        d0 = done_cnt[k];
        n  = 0;
        while (done_cnt[k] == d0 && n < budget) begin
            step();
            n++;
        end
        if (done_cnt[k] == d0) cmp("done_timeout", 0, 1);
    endtask

    task automatic check_seq0(string nm);
        int exp8 [8] = '{10, 11, 12, 13, 10, 11, 12, 13};
        cmp({nm, "_count"}, got[0].size(), 8);
        for (int i = 0; i < 8 && i < got[0].size(); i++) cmp({nm, "_word"}, got[0][i], exp8[i]);
    endtask

    initial begin
        int d0;
        rom0 = '{16'd10, 16'd11, 16'd12, 16'd13};
        rom2 = '{16'h7FFF};
        foreach (rom1[i]) rom1[i] = 16'($urandom);
        for (int k = 0; k < 3; k++) begin
            done_cnt[k] = 0;
            st_gc[k]    = 0;
            first_wr[k] = -1;
            last_wr[k]  = -100;
        end
        ifa.rom_q = '0;
        ifb.rom_q = '0;
        ifc.rom_q = '0;
        ifa.output_V_full_n = 1'b1;
        ifb.output_V_full_n = 1'b1;
        ifc.output_V_full_n = 1'b1;
        start = '0;
        rst_n = '0;
        step(3);
        rst_n = '1;
        step(2);

        // 1: nominal stream with exact latency
        do_start(0);
        wait_done(0, 100);
        @(negedge ap_clk);
        cmp("t1_idle_after_done", int'(idle[0]), 1);
        cmp("t1_first_write_cycle", first_wr[0], 3);
        cmp("t1_done_cycle", done_cyc[0], 11);
        check_seq0("t1");
        step(3);

        // 2: backpressure during cycles 5..9
        do_start(0);
        step(4);
        ifa.output_V_full_n = 1'b0;
        step(5);
        ifa.output_V_full_n = 1'b1;
        wait_done(0, 100);
        cmp("t2_resume_cycle10", int'(wr_at[0][10]), 1);
        cmp("t2_write_cycle4", int'(wr_at[0][4]), 1);
        check_seq0("t2");
        step(3);

        // 4: stray ap_start while busy is ignored
        d0 = done_cnt[0];
        do_start(0);
        step(5);
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        wait_done(0, 100);
        step(10);
        cmp("t4_single_done", done_cnt[0] - d0, 1);
        check_seq0("t4");

        // 5: reset mid-stream, then restart from address 0
        do_start(0);
        step(5);
        rst_n[0] = 1'b0;
        step(3);
        rst_n[0] = 1'b1;
        step(2);
        do_start(0);
        wait_done(0, 100);
        check_seq0("t5");
        step(3);

        // 3: 16x4 under random backpressure
        d0  = done_cnt[1];
        rnd = 1'b1;
        do_start(1);
        wait_done(1, 2000);
        rnd = 1'b0;
        ifb.output_V_full_n = 1'b1;
        step(20);
        cmp("t3_single_done", done_cnt[1] - d0, 1);
        cmp("t3_word_count", got[1].size(), 64);

        // 6: single-word ROM, single pass
        do_start(2);
        wait_done(2, 100);
        cmp("t6_first_write_cycle", first_wr[2], 3);
        cmp("t6_done_cycle", done_cyc[2], 4);
        cmp("t6_word_count", got[2].size(), 1);
        if (got[2].size() > 0) cmp("t6_word", got[2][0], 16'h7FFF);
        step(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
